// File: rtl/param_adjust_if.sv
// Setpoint adjust bus: enables and raw buttons in, setpoints and change pulse out.
interface param_adjust_if #(
    parameter int FREC_W = 4,
    parameter int COR_W  = 4
) ();
    logic              frec_en;
    logic              cor_en;
    logic              btn_up;
    logic              btn_down;
    logic [FREC_W-1:0] frec_val;
    logic [COR_W-1:0]  cor_val;
    logic              changed;

    modport master (
        output frec_en, cor_en, btn_up, btn_down,
        input  frec_val, cor_val, changed
    );

    modport slave (
        input  frec_en, cor_en, btn_up, btn_down,
        output frec_val, cor_val, changed
    );
endinterface

// File: rtl/param_adjust.sv
// Button-driven frequency/current setpoint stepper with sync, debounce and edge detect.
// Define PARAM_ADJUST_WRAP_EN to wrap at the limits instead of saturating.
module param_adjust #(
    parameter int DEB_CYCLES = 500000,
    parameter int FREC_W     = 4,
    parameter int COR_W      = 4,
    parameter int FREC_MAX   = 15,
    parameter int COR_MAX    = 15,
    parameter int FREC_RST   = 0,
    parameter int COR_RST    = 0
) (
    input logic          clk,
    input logic          reset,
    param_adjust_if.slave bus
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(DEB_CYCLES - 1);
    localparam logic [FREC_W-1:0] FMAX = FREC_W'(FREC_MAX);
    localparam logic [COR_W-1:0]  CMAX = COR_W'(COR_MAX);

    // index 0 = up, index 1 = down
    logic [1:0]    raw, s1, s2, db, prev;
    logic [CW-1:0] cnt [2];
    logic          up_p, dn_p;

    logic [FREC_W-1:0] frec_q, frec_nxt, frec_inc, frec_dec;
    logic [COR_W-1:0]  cor_q, cor_nxt, cor_inc, cor_dec;
    logic              changed_q;

    assign raw = {bus.btn_down, bus.btn_up};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            prev <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            prev <= db;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_TOP) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign up_p = db[0] & ~prev[0];
    assign dn_p = db[1] & ~prev[1];

`ifdef PARAM_ADJUST_WRAP_EN
    assign frec_inc = (frec_q >= FMAX) ? '0 : frec_q + 1'b1;
    assign frec_dec = (frec_q == '0) ? FMAX : frec_q - 1'b1;
    assign cor_inc  = (cor_q >= CMAX) ? '0 : cor_q + 1'b1;
    assign cor_dec  = (cor_q == '0) ? CMAX : cor_q - 1'b1;
`else
    assign frec_inc = (frec_q >= FMAX) ? frec_q : frec_q + 1'b1;
    assign frec_dec = (frec_q == '0) ? frec_q : frec_q - 1'b1;
    assign cor_inc  = (cor_q >= CMAX) ? cor_q : cor_q + 1'b1;
    assign cor_dec  = (cor_q == '0) ? cor_q : cor_q - 1'b1;
`endif

    // Simultaneous up/down presses fall through to default and are dropped.
    always_comb begin
        frec_nxt = frec_q;
        cor_nxt  = cor_q;
        unique case (1'b1)
            up_p & ~dn_p: begin
                if (bus.frec_en) frec_nxt = frec_inc;
                if (bus.cor_en)  cor_nxt  = cor_inc;
            end
            dn_p & ~up_p: begin
                if (bus.frec_en) frec_nxt = frec_dec;
                if (bus.cor_en)  cor_nxt  = cor_dec;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frec_q    <= FREC_W'(FREC_RST);
            cor_q     <= COR_W'(COR_RST);
            changed_q <= 1'b0;
        end else begin
            frec_q    <= frec_nxt;
            cor_q     <= cor_nxt;
            changed_q <= (frec_nxt != frec_q) | (cor_nxt != cor_q);
        end
    end

    assign bus.frec_val = frec_q;
    assign bus.cor_val  = cor_q;
    assign bus.changed  = changed_q;
endmodule
